// File: rtl/pipe_clock_ctrl_if.sv
// pipe_clock_ctrl_if: bundle of the PIPE clock sequencer's status and control
// signals. The rate-change counter CLK_RATE_CHANGES exists only when the
// CLK_STATS_EN macro is defined.
// master: the sequencer (drives GT_RATE, PCLK select, PHYSTATUS, status).
// slave: the surrounding MAC/GT/MMCM side.
interface pipe_clock_ctrl_if #(
  parameter int LANES = 1
);
  logic             CLK_MMCM_LOCK;
  logic             PIPE_RATE;
  logic [LANES-1:0] GT_TXRATEDONE;
  logic             GT_RATE;
  logic             CLK_PCLK_SEL;
  logic [LANES-1:0] PIPE_PHYSTATUS;
  logic             CLK_READY;
  logic             CLK_ERR;
`ifdef CLK_STATS_EN
  logic [15:0]      CLK_RATE_CHANGES;

  modport master (
    input  CLK_MMCM_LOCK, PIPE_RATE, GT_TXRATEDONE,
    output GT_RATE, CLK_PCLK_SEL, PIPE_PHYSTATUS, CLK_READY, CLK_ERR,
           CLK_RATE_CHANGES
  );

  modport slave (
    output CLK_MMCM_LOCK, PIPE_RATE, GT_TXRATEDONE,
    input  GT_RATE, CLK_PCLK_SEL, PIPE_PHYSTATUS, CLK_READY, CLK_ERR,
           CLK_RATE_CHANGES
  );
`else
  modport master (
    input  CLK_MMCM_LOCK, PIPE_RATE, GT_TXRATEDONE,
    output GT_RATE, CLK_PCLK_SEL, PIPE_PHYSTATUS, CLK_READY, CLK_ERR
  );

  modport slave (
    output CLK_MMCM_LOCK, PIPE_RATE, GT_TXRATEDONE,
    input  GT_RATE, CLK_PCLK_SEL, PIPE_PHYSTATUS, CLK_READY, CLK_ERR
  );
`endif
endinterface

// File: rtl/pipe_clock_ctrl.sv
// pipe_clock_ctrl: Gen1/Gen2 rate-change and lock sequencer for the PIPE
// clocking path. Synchronises MMCM lock, broadcasts the GT rate, collects
// per-lane TXRATEDONE, flips the PCLK BUFGCTRL select, waits for the clock to
// settle and reports completion as a one-cycle PHYSTATUS pulse on all lanes.
// Optional feature macro: CLK_STATS_EN adds a saturating 16-bit count of
// completed rate changes (CLK_RATE_CHANGES). Without it the port is absent.
module pipe_clock_ctrl #(
  parameter int LANES         = 1,
  parameter int SETTLE_CYCLES = 64,
  parameter int RATE_TIMEOUT  = 65535
) (
  input  logic               CLK_DCLK,
  input  logic               CLK_RST,
  pipe_clock_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    IDLE      = 3'd1,
    RATE_GT   = 3'd2,
    SEL       = 3'd3,
    SETTLE    = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(RATE_TIMEOUT + 1);
  // SETTLE ends after the counter has reached SETTLE_CYCLES, which places the
  // PHYSTATUS pulse SETTLE_CYCLES+1 cycles after the select change.
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES);
  // The timeout counter starts at 0 on RATE_GT entry, so matching
  // RATE_TIMEOUT-1 raises the error exactly RATE_TIMEOUT cycles after entry.
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(RATE_TIMEOUT - 1);

  state_t           state;
  logic             lock_meta;
  logic             lock_s;
  logic             target;
  logic             gt_rate;
  logic             pclk_sel;
  logic [LANES-1:0] phystatus;
  logic             ready;
  logic             err;
  logic [LANES-1:0] mask;
  logic [LANES-1:0] mask_next;
  logic             all_done;
  logic [SW-1:0]    settle_cnt;
  logic [TW-1:0]    tmo_cnt;
`ifdef CLK_STATS_EN
  logic [15:0]      rate_changes;
`endif

  // Two-flop synchroniser for the asynchronous MMCM LOCKED.
  always_ff @(posedge CLK_DCLK or posedge CLK_RST) begin
    if (CLK_RST) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.CLK_MMCM_LOCK;
      lock_s    <= lock_meta;
    end
  end

  // Sticky per-lane done collection; the current cycle's pulses are folded in
  // so a TXRATEDONE in the RATE_GT entry cycle (or the final one) counts.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
      assign mask_next[gi] = mask[gi] | bus.GT_TXRATEDONE[gi];
    end
  endgenerate

  assign all_done = &mask_next;

  // Sequencer FSM with registered outputs; lock loss overrides every state.
  always_ff @(posedge CLK_DCLK or posedge CLK_RST) begin
    if (CLK_RST) begin
      state        <= WAIT_LOCK;
      target       <= 1'b0;
      gt_rate      <= 1'b0;
      pclk_sel     <= 1'b0;
      phystatus    <= '0;
      ready        <= 1'b0;
      err          <= 1'b0;
      mask         <= '0;
      settle_cnt   <= '0;
      tmo_cnt      <= '0;
`ifdef CLK_STATS_EN
      rate_changes <= 16'h0000;
`endif
    end else begin
      // PHYSTATUS is a single-cycle pulse unless a state below re-asserts it.
      phystatus <= '0;
      if ((state != WAIT_LOCK) && !lock_s) begin
        // Abort: GT rate and PCLK select keep their values, no pulse.
        state <= WAIT_LOCK;
        ready <= 1'b0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            if (lock_s) begin
              state     <= DONE;
              phystatus <= '1;
            end
          end
          IDLE: begin
            if (bus.PIPE_RATE != gt_rate) begin
              target  <= bus.PIPE_RATE;
              gt_rate <= bus.PIPE_RATE;
              mask    <= '0;
              tmo_cnt <= '0;
              ready   <= 1'b0;
              state   <= RATE_GT;
            end
          end
          RATE_GT: begin
            mask <= mask_next;
            if (all_done) begin
              state <= SEL;
            end else if (tmo_cnt == TIMEOUT_LAST) begin
              err   <= 1'b1;
              state <= SEL;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          SEL: begin
            pclk_sel   <= target;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
          SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              phystatus <= '1;
              state     <= DONE;
`ifdef CLK_STATS_EN
              // Only rate changes pass through SETTLE, so the power-up
              // DONE is never counted.
              if (rate_changes != 16'hFFFF) begin
                rate_changes <= rate_changes + 16'd1;
              end
`endif
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end
          DONE: begin
            ready <= 1'b1;
            state <= IDLE;
          end
          default: begin
            state <= WAIT_LOCK;
            ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.GT_RATE          = gt_rate;
  assign bus.CLK_PCLK_SEL     = pclk_sel;
  assign bus.PIPE_PHYSTATUS   = phystatus;
  assign bus.CLK_READY        = ready;
  assign bus.CLK_ERR          = err;
`ifdef CLK_STATS_EN
  assign bus.CLK_RATE_CHANGES = rate_changes;
`endif

endmodule

// File: tb/tb_pipe_clock_ctrl.sv
// tb_pipe_clock_ctrl: directed bench for pipe_clock_ctrl with LANES=4,
// SETTLE_CYCLES=8, RATE_TIMEOUT=100. Cycle k means 1 ns after clock edge k
// counted from the start of each scenario; inputs are driven at that point.
module tb_pipe_clock_ctrl;

  localparam int LANES  = 4;
  localparam int SETTLE = 8;
  localparam int TMO    = 100;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipe_clock_ctrl_if #(.LANES(LANES)) bus ();

  pipe_clock_ctrl #(
    .LANES(LANES),
    .SETTLE_CYCLES(SETTLE),
    .RATE_TIMEOUT(TMO)
  ) dut (
    .CLK_DCLK(clk),
    .CLK_RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_phys;
    logic       exp_ready;
    rst = 1'b1;
    bus.CLK_MMCM_LOCK = 1'b0;
    bus.PIPE_RATE = 1'b0;
    bus.GT_TXRATEDONE = 4'h0;
    tick();
    tick();
    checks++;
    if ({bus.GT_RATE, bus.CLK_PCLK_SEL, bus.CLK_READY, bus.CLK_ERR, bus.PIPE_PHYSTATUS} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000000",
               {bus.GT_RATE, bus.CLK_PCLK_SEL, bus.CLK_READY, bus.CLK_ERR, bus.PIPE_PHYSTATUS});
    end
`ifdef CLK_STATS_EN
    checks++;
    if (bus.CLK_RATE_CHANGES !== 16'd0) begin
      failures++;
      $display("FAIL reset_stats got=%0d exp=0", bus.CLK_RATE_CHANGES);
    end
`endif
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 10) bus.CLK_MMCM_LOCK = 1'b1;
      exp_phys  = (k == 13) ? 4'hF : 4'h0;
      exp_ready = (k >= 14);
      checks++;
      if (bus.PIPE_PHYSTATUS !== exp_phys) begin
        failures++;
        $display("FAIL powerup_phys k=%0d got=%h exp=%h", k, bus.PIPE_PHYSTATUS, exp_phys);
      end
      checks++;
      if (bus.CLK_READY !== exp_ready) begin
        failures++;
        $display("FAIL powerup_ready k=%0d got=%b exp=%b", k, bus.CLK_READY, exp_ready);
      end
    end
    checks++;
    if ({bus.GT_RATE, bus.CLK_PCLK_SEL, bus.CLK_ERR} !== 3'b000) begin
      failures++;
      $display("FAIL powerup_rate_sel got=%b exp=000", {bus.GT_RATE, bus.CLK_PCLK_SEL, bus.CLK_ERR});
    end
    $display("powerup: PHYSTATUS pulse and READY checked");
  endtask

  task automatic test_rate_up();
    logic [3:0] exp_phys;
    logic       exp_sel;
    logic       exp_ready;
    bus.PIPE_RATE = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      bus.GT_TXRATEDONE = (k == 5) ? 4'b0001 : (k == 7) ? 4'b0010 :
                          (k == 9) ? 4'b0100 : (k == 11) ? 4'b1000 : 4'b0000;
      exp_phys  = (k == 22) ? 4'hF : 4'h0;
      exp_sel   = (k >= 13);
      exp_ready = (k >= 23);
      checks++;
      if (bus.GT_RATE !== 1'b1) begin
        failures++;
        $display("FAIL rate_up_gt k=%0d got=%b exp=1", k, bus.GT_RATE);
      end
      checks++;
      if (bus.CLK_PCLK_SEL !== exp_sel) begin
        failures++;
        $display("FAIL rate_up_sel k=%0d got=%b exp=%b", k, bus.CLK_PCLK_SEL, exp_sel);
      end
      checks++;
      if (bus.PIPE_PHYSTATUS !== exp_phys) begin
        failures++;
        $display("FAIL rate_up_phys k=%0d got=%h exp=%h", k, bus.PIPE_PHYSTATUS, exp_phys);
      end
      checks++;
      if (bus.CLK_READY !== exp_ready) begin
        failures++;
        $display("FAIL rate_up_ready k=%0d got=%b exp=%b", k, bus.CLK_READY, exp_ready);
      end
    end
    checks++;
    if (bus.CLK_ERR !== 1'b0) begin
      failures++;
      $display("FAIL rate_up_err got=%b exp=0", bus.CLK_ERR);
    end
`ifdef CLK_STATS_EN
    checks++;
    if (bus.CLK_RATE_CHANGES !== 16'd1) begin
      failures++;
      $display("FAIL rate_up_stats got=%0d exp=1", bus.CLK_RATE_CHANGES);
    end
`endif
    $display("rate_up: Gen1->Gen2 change checked");
  endtask

  task automatic test_timeout();
    logic [3:0] exp_phys;
    logic       exp_err;
    logic       exp_sel;
    logic       exp_ready;
    bus.PIPE_RATE = 1'b0;
    for (int k = 1; k <= 112; k++) begin
      tick();
      bus.GT_TXRATEDONE = (k == 3) ? 4'b1011 : 4'b0000;
      exp_err   = (k >= 101);
      exp_sel   = (k < 102);
      exp_phys  = (k == 111) ? 4'hF : 4'h0;
      exp_ready = (k >= 112);
      checks++;
      if (bus.CLK_ERR !== exp_err) begin
        failures++;
        $display("FAIL timeout_err k=%0d got=%b exp=%b", k, bus.CLK_ERR, exp_err);
      end
      checks++;
      if (bus.CLK_PCLK_SEL !== exp_sel) begin
        failures++;
        $display("FAIL timeout_sel k=%0d got=%b exp=%b", k, bus.CLK_PCLK_SEL, exp_sel);
      end
      checks++;
      if (bus.PIPE_PHYSTATUS !== exp_phys) begin
        failures++;
        $display("FAIL timeout_phys k=%0d got=%h exp=%h", k, bus.PIPE_PHYSTATUS, exp_phys);
      end
      checks++;
      if (bus.CLK_READY !== exp_ready) begin
        failures++;
        $display("FAIL timeout_ready k=%0d got=%b exp=%b", k, bus.CLK_READY, exp_ready);
      end
      checks++;
      if (bus.GT_RATE !== 1'b0) begin
        failures++;
        $display("FAIL timeout_gt k=%0d got=%b exp=0", k, bus.GT_RATE);
      end
    end
`ifdef CLK_STATS_EN
    checks++;
    if (bus.CLK_RATE_CHANGES !== 16'd2) begin
      failures++;
      $display("FAIL timeout_stats got=%0d exp=2", bus.CLK_RATE_CHANGES);
    end
`endif
    $display("timeout: lane 2 silent, CLK_ERR and completion checked");
  endtask

  task automatic test_lock_loss();
    logic [3:0] exp_phys;
    logic       exp_sel;
    logic       exp_ready;
    // Change to Gen2, drop lock in SETTLE, then re-lock.
    bus.PIPE_RATE = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      bus.GT_TXRATEDONE = (k == 2) ? 4'hF : 4'h0;
      if (k == 6)  bus.CLK_MMCM_LOCK = 1'b0;
      if (k == 20) bus.CLK_MMCM_LOCK = 1'b1;
      exp_phys  = (k == 23) ? 4'hF : 4'h0;
      exp_sel   = (k >= 4);
      exp_ready = (k >= 24);
      checks++;
      if (bus.PIPE_PHYSTATUS !== exp_phys) begin
        failures++;
        $display("FAIL lockloss_phys k=%0d got=%h exp=%h", k, bus.PIPE_PHYSTATUS, exp_phys);
      end
      checks++;
      if (bus.CLK_PCLK_SEL !== exp_sel) begin
        failures++;
        $display("FAIL lockloss_sel k=%0d got=%b exp=%b", k, bus.CLK_PCLK_SEL, exp_sel);
      end
      checks++;
      if (bus.CLK_READY !== exp_ready) begin
        failures++;
        $display("FAIL lockloss_ready k=%0d got=%b exp=%b", k, bus.CLK_READY, exp_ready);
      end
      checks++;
      if (bus.GT_RATE !== 1'b1) begin
        failures++;
        $display("FAIL lockloss_gt k=%0d got=%b exp=1", k, bus.GT_RATE);
      end
    end
    checks++;
    if (bus.CLK_ERR !== 1'b1) begin
      failures++;
      $display("FAIL lockloss_err_sticky got=%b exp=1", bus.CLK_ERR);
    end
`ifdef CLK_STATS_EN
    checks++;
    if (bus.CLK_RATE_CHANGES !== 16'd2) begin
      failures++;
      $display("FAIL lockloss_stats got=%0d exp=2", bus.CLK_RATE_CHANGES);
    end
`endif
    // Lock loss while IDLE: READY falls 3 cycles later.
    bus.CLK_MMCM_LOCK = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_ready = (k < 3);
      checks++;
      if (bus.CLK_READY !== exp_ready) begin
        failures++;
        $display("FAIL idle_lockloss_ready k=%0d got=%b exp=%b", k, bus.CLK_READY, exp_ready);
      end
    end
    bus.CLK_MMCM_LOCK = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    checks++;
    if (bus.CLK_READY !== 1'b1) begin
      failures++;
      $display("FAIL relock_ready got=%b exp=1", bus.CLK_READY);
    end
    $display("lock_loss: abort in SETTLE and IDLE, re-lock checked");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_phys;
    logic       exp_gt;
    logic       exp_sel;
    logic       exp_ready;
    bus.PIPE_RATE = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 2) bus.PIPE_RATE = 1'b1;
      bus.GT_TXRATEDONE = ((k == 3) || (k == 18)) ? 4'hF : 4'h0;
      exp_gt    = (k >= 16);
      exp_sel   = (k < 5) || (k >= 20);
      exp_phys  = ((k == 14) || (k == 29)) ? 4'hF : 4'h0;
      exp_ready = (k == 15) || (k >= 30);
      checks++;
      if (bus.GT_RATE !== exp_gt) begin
        failures++;
        $display("FAIL b2b_gt k=%0d got=%b exp=%b", k, bus.GT_RATE, exp_gt);
      end
      checks++;
      if (bus.CLK_PCLK_SEL !== exp_sel) begin
        failures++;
        $display("FAIL b2b_sel k=%0d got=%b exp=%b", k, bus.CLK_PCLK_SEL, exp_sel);
      end
      checks++;
      if (bus.PIPE_PHYSTATUS !== exp_phys) begin
        failures++;
        $display("FAIL b2b_phys k=%0d got=%h exp=%h", k, bus.PIPE_PHYSTATUS, exp_phys);
      end
      checks++;
      if (bus.CLK_READY !== exp_ready) begin
        failures++;
        $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, bus.CLK_READY, exp_ready);
      end
    end
    checks++;
    if (bus.CLK_ERR !== 1'b1) begin
      failures++;
      $display("FAIL b2b_err_sticky got=%b exp=1", bus.CLK_ERR);
    end
`ifdef CLK_STATS_EN
    checks++;
    if (bus.CLK_RATE_CHANGES !== 16'd4) begin
      failures++;
      $display("FAIL b2b_stats got=%0d exp=4", bus.CLK_RATE_CHANGES);
    end
`endif
    $display("back_to_back: reverted request restarts change checked");
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_phys;
    bus.PIPE_RATE = 1'b0;
    tick();
    tick();
    tick();
    // Assert reset between clock edges; outputs must clear without an edge.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.GT_RATE, bus.CLK_PCLK_SEL, bus.CLK_READY, bus.CLK_ERR, bus.PIPE_PHYSTATUS} !== 8'h00) begin
      failures++;
      $display("FAIL async_reset_outputs got=%b exp=00000000",
               {bus.GT_RATE, bus.CLK_PCLK_SEL, bus.CLK_READY, bus.CLK_ERR, bus.PIPE_PHYSTATUS});
    end
`ifdef CLK_STATS_EN
    checks++;
    if (bus.CLK_RATE_CHANGES !== 16'd0) begin
      failures++;
      $display("FAIL async_reset_stats got=%0d exp=0", bus.CLK_RATE_CHANGES);
    end
`endif
    tick();
    rst = 1'b0;
    // Lock is still present: power-up pulse 3 cycles after reset release.
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_phys = (k == 3) ? 4'hF : 4'h0;
      checks++;
      if (bus.PIPE_PHYSTATUS !== exp_phys) begin
        failures++;
        $display("FAIL post_reset_phys k=%0d got=%h exp=%h", k, bus.PIPE_PHYSTATUS, exp_phys);
      end
    end
    $display("async_reset: mid-RATE_GT reset checked");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_rate_up();
    test_timeout();
    test_lock_loss();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_clock_ctrl.md
# pipe_clock_ctrl

Parametrised rate-change and lock sequencer for the PIPE clocking path, the Gen1/Gen2 successor to the fixed Gen1 PIPE clock wrapper. Runs on the free-running DRP/sequencer clock. Monitors MMCM lock, drives the GT rate for N lanes, collects per-lane TXRATEDONE, and switches the PCLK BUFGCTRL select between 125 MHz and 250 MHz. Reports completion to the MAC as per-lane PIPE PHYSTATUS pulses.

## Interface
- LANES, 1, number of GT lanes (1..16)
- SETTLE_CYCLES, 64, CLK_DCLK cycles held after a PCLK select change (≥2)
- RATE_TIMEOUT, 65535, maximum CLK_DCLK cycles to wait for all TXRATEDONE
- CLK_DCLK  in  1  sequencer clock; only clock of the block
- CLK_RST  in  1  reset, asynchronous, active-high
- CLK_MMCM_LOCK  in  1  MMCM LOCKED, asynchronous to CLK_DCLK
- PIPE_RATE  in  1  requested rate, level: 0 = Gen1, 1 = Gen2
- GT_TXRATEDONE  in  LANES  per-lane single-cycle done pulse, synchronous to CLK_DCLK
- GT_RATE  out  1  rate broadcast to all GTs
- CLK_PCLK_SEL  out  1  BUFGCTRL select: 0 = 125 MHz, 1 = 250 MHz
- PIPE_PHYSTATUS  out  LANES  single-cycle completion pulse, same value on every bit
- CLK_READY  out  1  high while in IDLE with lock present
- CLK_ERR  out  1  sticky rate-change timeout flag
- CLK_RATE_CHANGES  out  16  completed rate changes (only with CLK_STATS_EN)

## Operation
- CLK_MMCM_LOCK passes a 2-flop synchroniser; lock_s is the output.
- States: WAIT_LOCK, IDLE, RATE_GT, SEL, SETTLE, DONE.
- WAIT_LOCK: outputs held; on lock_s = 1 go to DONE (power-up PHYSTATUS pulse), then IDLE.
- IDLE: CLK_READY = 1. If PIPE_RATE != GT_RATE, latch target = PIPE_RATE and go to RATE_GT.
- RATE_GT: GT_RATE = target on entry; done-mask cleared on entry; each GT_TXRATEDONE bit sets its mask bit (sticky). All mask bits set → SEL. Timeout counter reaches RATE_TIMEOUT → set CLK_ERR, go to SEL anyway.
- SEL: CLK_PCLK_SEL = target; go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then DONE.
- DONE: PIPE_PHYSTATUS = all ones for exactly one cycle, then IDLE.
- Lock loss (lock_s = 0) in any state other than WAIT_LOCK: abort immediately to WAIT_LOCK, CLK_READY = 0, no PHYSTATUS pulse for the aborted change. GT_RATE and CLK_PCLK_SEL keep their current values.
- PIPE_RATE changing during RATE_GT/SEL/SETTLE is ignored. IDLE re-compares after DONE, so a reverted request starts a new change.
- GT_TXRATEDONE outside RATE_GT is ignored. A TXRATEDONE in the RATE_GT entry cycle counts.
- CLK_ERR clears only on CLK_RST.
- Counter widths are $clog2(param+1).

## Timing
- Reset values: state WAIT_LOCK; GT_RATE 0, CLK_PCLK_SEL 0, PIPE_PHYSTATUS 0, CLK_READY 0, CLK_ERR 0, CLK_RATE_CHANGES 0, mask 0, counters 0.
- Lock rise to DONE entry: 3 cycles (2 sync + 1 state). CLK_READY rises 1 cycle after the PHYSTATUS pulse.
- PIPE_RATE toggle in IDLE: GT_RATE updates 1 cycle later, and CLK_READY falls in the same cycle.
- Last TXRATEDONE to CLK_PCLK_SEL update: 2 cycles.
- CLK_PCLK_SEL update to PHYSTATUS pulse: SETTLE_CYCLES+1 cycles.
- Timeout: CLK_ERR rises RATE_TIMEOUT cycles after RATE_GT entry.
- Lock fall to CLK_READY low: 3 cycles.
- All outputs are registered.

## Configuration
- CLK_STATS_EN defined: CLK_RATE_CHANGES port exists and increments in each DONE that closes a rate change (not the power-up DONE). Saturates at 0xFFFF.
- CLK_STATS_EN undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset, LANES=4, raise lock at cycle 10 → PHYSTATUS=4'hF for one cycle at cycle 13, CLK_READY=1 at cycle 14, GT_RATE=0, CLK_PCLK_SEL=0.
- In IDLE, PIPE_RATE 0→1; lanes pulse TXRATEDONE at +5,+7,+9,+11 → GT_RATE=1 at +1, CLK_PCLK_SEL=1 at +13, PHYSTATUS pulse at +13+SETTLE_CYCLES+1, CLK_RATE_CHANGES=1.
- RATE_TIMEOUT=100, lane 2 never reports done → CLK_ERR=1 at 100 cycles after RATE_GT entry, change still completes with PHYSTATUS; CLK_ERR stays 1 through later changes.
- Drop lock during SETTLE → CLK_READY stays 0, no PHYSTATUS. Re-lock → power-up PHYSTATUS pulse, then IDLE with CLK_PCLK_SEL=1 retained.
- Toggle PIPE_RATE 1→0→1 within RATE_GT → first change completes to 0, then a second change to 1 starts 1 cycle after IDLE.
- Assert CLK_RST mid-RATE_GT → all outputs 0 asynchronously; CLK_ERR and CLK_RATE_CHANGES cleared.
